// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore sequencer for the 16-bit datapath. Latches one
// instruction per start pulse, walks it through the read/execute/writeback
// states and drives every datapath strobe from the current state and the
// latched instruction.
// Optional: define DATAPATH_CTRL_RETIRE_CNT_EN to add the 16-bit 'retired'
// counter output (counts completed legal instructions).
module datapath_ctrl #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [15:0]       in,
  output logic              w,
  output logic              err,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic [1:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5
`ifdef DATAPATH_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]       retired
`endif
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_REG
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        err_q, err_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

  // Field extraction and instruction classification from the latched ir
  always_comb begin
    opcode     = ir_q[15:13];
    op         = ir_q[12:11];
    rn         = ir_q[10:8];
    rd         = ir_q[7:5];
    sh         = ir_q[4:3];
    rm         = ir_q[2:0];
    is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    is_alu     = (opcode == 3'b101);
    is_cmp     = is_alu && (op == 2'b01);
    is_mvn     = is_alu && (op == 2'b11);
  end

  // Next-state, instruction latch and sticky error flag
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q;
    unique case (state_q)
      S_WAIT: begin
        if (s) begin
          ir_d    = in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov_imm)                state_d = S_WR_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else if (is_alu)               state_d = S_GET_A;
        else begin
          state_d = S_WAIT;
          err_d   = 1'b1;
        end
      end
      S_WR_IMM: state_d = S_WAIT;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:   state_d = is_cmp ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  // State, instruction and error registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs: strobes decoded from state and latched ir only
  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    unique case (state_q)
      S_WAIT: w = 1'b1;
      S_WR_IMM: begin
        write    = 1'b1;
        writenum = rn;
        vsel     = 2'b01;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = sh;
        ALUop = is_alu ? op : 2'b00;
        asel  = is_mov_reg;
        loadc = !is_cmp;
        loads = is_cmp;
      end
      S_WR_REG: begin
        write    = 1'b1;
        writenum = rd;
        vsel     = 2'b00;
      end
      default: ;
    endcase
  end

  assign err    = err_q;
  assign sximm8 = DATA_W'($signed(ir_q[7:0]));
  assign sximm5 = DATA_W'($signed(ir_q[4:0]));

`ifdef DATAPATH_CTRL_RETIRE_CNT_EN
  logic [15:0] retired_q, retired_d;
  logic        retire;

  // A legal instruction retires on its last non-WAIT state
  always_comb begin
    retire    = (state_q == S_WR_IMM) || (state_q == S_WR_REG) ||
                ((state_q == S_EXEC) && is_cmp);
    retired_d = retired_q + 16'(retire);
  end

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Moore FSM that sequences the 16-bit datapath (register file, A/B/C registers, shifter, ALU, status register) through one instruction at a time.
- Latches a 16-bit instruction on a start pulse, decodes it, and drives every datapath control strobe.
- Produces the sign-extended immediates and raises w when idle.
- Sits between the instruction register/top-level CPU and the datapath.

Parameters:
DATA_W, 16, width of sximm8/sximm5 outputs (≥8)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
s  input  1  start; sampled only in WAIT
in  input  16  instruction word
w  output  1  1 while in WAIT (ready for next instruction)
err  output  1  sticky illegal-instruction flag
readnum  output  3  register-file read index
writenum  output  3  register-file write index
write  output  1  register-file write enable
vsel  output  2  writeback select: 00=C, 01=sximm8, 10=PC, 11=mdata
loada  output  1  A register load
loadb  output  1  B register load
loadc  output  1  C register load
loads  output  1  status register load
asel  output  1  1: A operand forced to 0
bsel  output  1  1: B operand = sximm5
shift  output  2  shifter op: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
sximm8  output  DATA_W  sign-extended ir[7:0]
sximm5  output  DATA_W  sign-extended ir[4:0]

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Encoding of latched ir: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm.
- Instruction decode:
  - 110/10 MOV Rn,#imm8.
  - 110/00 MOV Rd,Rm{sh}.
  - 101/00 ADD Rd,Rn,Rm{sh}.
  - 101/01 CMP Rn,Rm{sh}.
  - 101/10 AND Rd,Rn,Rm{sh}.
  - 101/11 MVN Rd,Rm{sh}.
  - Anything else is illegal.
- States: WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, WR_REG.
- Outputs are pure functions of state and ir. Every strobe not listed for a state is 0; vsel, shift, ALUop, asel and bsel are also 0.
- WAIT: w=1.
  - s=1 at an edge: ir<=in, go to DECODE.
  - s=0: stay in WAIT.
- DECODE:
  - MOV imm → WR_IMM.
  - MOV reg or MVN → GET_B.
  - ADD/CMP/AND → GET_A.
  - Illegal → WAIT with err<=1.
- WR_IMM: write=1, writenum=Rn, vsel=01 → WAIT.
- GET_A: readnum=Rn, loada=1 → GET_B.
- GET_B: readnum=Rm, loadb=1 → EXEC.
- EXEC: loadc=1, shift=sh.
  - ALUop=op for 101 instructions; 00 for MOV reg.
  - asel=1 for MOV reg only.
  - CMP: loads=1, loadc=0 → WAIT.
  - All others → WR_REG.
- WR_REG: write=1, writenum=Rd, vsel=00 → WAIT.
- Latency, counted from the edge sampling s to the first cycle with w=1 again:
  - MOV imm: 3 cycles.
  - MOV reg / MVN: 5 cycles.
  - ADD/AND: 6 cycles.
  - CMP: 5 cycles.
  - Illegal: 2 cycles.
- sximm8 and sximm5 are continuous and derived from ir, not from in.
- s outside WAIT is ignored.
- If s is held high, a new instruction is latched at every edge in WAIT; WAIT lasts exactly one cycle between instructions.
- Reset (any state, including mid-instruction): next state WAIT, ir<=0, err<=0. All strobes are 0 and w=1 in the cycle after reset. Reset has priority over s.
- err stays set until reset; legal instructions still execute after err is set.

Optional Feature:
- Macro DATAPATH_CTRL_RETIRE_CNT_EN.
- When defined: adds output retired [15:0].
  - Reset value 0.
  - Increments by 1 on each transition into WAIT from WR_IMM, WR_REG or EXEC(CMP).
  - Does not increment for illegal instructions.
  - Wraps from 16'hFFFF to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then in=16'hD134 (MOV R1,#0x34), s pulse:
  - DECODE next cycle, then WR_IMM with write=1, writenum=1, vsel=01, sximm8=16'h0034.
  - w=1 three cycles after the s edge.
- in=16'hD2FF (MOV R2,#-1) → sximm8=16'hFFFF during WR_IMM.
- in=16'hA1A2 (ADD R5,R1,R2):
  - Strobe sequence loada (readnum=1), then loadb (readnum=2), then loadc with ALUop=00.
  - Then write=1, writenum=5, vsel=00.
  - w returns after 6 cycles.
- in=16'hA94A (CMP R1,R2, sh=01):
  - EXEC shows loads=1, loadc=0, shift=01, ALUop=01.
  - No write in any cycle.
  - w after 5 cycles.
- in=16'hE000 (illegal): err=1 two cycles after s and no strobes asserted. A following legal MOV still executes; err stays 1.
- Start ADD, assert reset during GET_B: next cycle state is WAIT, w=1, all strobes 0, err=0. With the macro defined, retired also reads 0 after reset, and 1 after a single completed MOV.
